conversor_bin_bcd_seq: RTL and testbench
========================================

// Module: conversor_bin_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
//   Sits directly upstream of the output/display stage: converts the CPU OUT value (or PC/FP)
//   into packed BCD digits, replacing wide combinational % and / chains that limit fmax.
//   Uses a valid/ready input handshake and a one-cycle out_valid pulse; the result is held
//   on bcd_out until the next conversion completes.
// PARAMETERS
//   WIDTH   32  binary input width (>=4)
//   DIGITS  10  number of BCD digits produced (10 covers 2^32-1)
//   SIGNED  0   1: treat bin_in as two's complement, convert |value|, report sign on negative
// PORTS
//   clk        in   1           system clock; all logic is on its rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   in_valid   in   1           bin_in is valid this cycle
//   in_ready   out  1           converter idle; accepts when in_valid && in_ready
//   bin_in     in   WIDTH       binary value to convert
//   out_valid  out  1           one-cycle pulse: bcd_out/negative/overflow updated
//   bcd_out    out  4*DIGITS    packed BCD; [3:0]=units, [7:4]=tens, ...
//   negative   out  1           SIGNED=1 and accepted input was negative; 0 when SIGNED=0
//   overflow   out  1           value >= 10^DIGITS; bcd_out then holds value mod 10^DIGITS
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; bcd_out=0; negative=0;
//     overflow=0; scratch registers and bit counter cleared. Reset mid-conversion aborts it;
//     no out_valid is produced for the aborted value.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. On the edge where in_valid=1: load bin_reg = (SIGNED && bin_in[MSB]) ?
//     -bin_in : bin_in (WIDTH-bit magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1)); latch sign;
//     bcd_scratch=0; ovf_scratch=0; cnt=0; go to SHIFT.
//   SHIFT (in_ready=0), one iteration per cycle:
//     - every scratch digit >=5 gets +3 (all digits in parallel, 4-bit result);
//     - shift {bcd_scratch, bin_reg} left by 1; the bit leaving the top digit ORs into ovf_scratch;
//     - cnt increments; on the iteration with cnt==WIDTH-1 go to DONE.
//   DONE (in_ready=0): bcd_out<=bcd_scratch; negative<=sign; overflow<=ovf_scratch;
//     out_valid<=1 (registered, visible the following cycle); go to IDLE.
//   Latency: the accept edge is cycle 0; out_valid is high during cycle WIDTH+2
//     (34 for WIDTH=32). Minimum spacing between accepts is WIDTH+2 cycles.
//   in_valid while in_ready=0 is ignored, not queued; the producer holds it until accepted.
//   in_valid held high continuously: a new accept occurs on the same edge on which out_valid
//     for the previous result rises (IDLE entered).
//   bcd_out, negative and overflow change only on the out_valid edge; they are stable otherwise.
//   out_valid is never high for two consecutive cycles.
//   Digits never exceed 9 in bcd_out. Counter width = clog2(WIDTH).
// TESTING
//   1. Reset, then bin_in=0, in_valid pulse -> out_valid exactly 34 cycles later; bcd_out=0,
//      overflow=0, negative=0; in_ready low from cycle 1 to cycle 33.
//   2. bin_in=32'hFFFFFFFF -> bcd_out=40'h4294967295, overflow=0.
//   3. DIGITS=4: bin_in=12345 -> bcd_out=16'h2345, overflow=1; bin_in=9999 -> 16'h9999, overflow=0.
//   4. SIGNED=1: bin_in=-1 -> bcd_out=1, negative=1; bin_in=32'h80000000 -> 40'h2147483648, negative=1.
//   5. Accept 1234, drop rst_n at cycle 10 for 2 cycles -> no out_valid for 1234, all outputs 0;
//      then accept 56 -> bcd_out=40'h56.
//   6. in_valid held high, bin_in changes mid-conversion from 7 to 8 -> the first result is 7;
//      the second accept coincides with the out_valid edge; out_valid pulses are 34 cycles apart.

Source files
------------

// File: rtl/conversor_bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock); accept edge is cycle 0,
// out_valid pulses WIDTH+2 cycles later. in_ready is low while busy; in_valid is ignored then, not queued.
module conversor_bin_bcd_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10,
   parameter bit SIGNED = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    bin_in,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                negative,
   output logic                overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] bin_reg;
   logic [BW-1:0]    bcd_scratch;
   logic [BW-1:0]    bcd_adj;
   logic             ovf_scratch;
   logic             sign_reg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last_bit;
   logic             in_neg;

   assign in_neg = SIGNED && bin_in[WIDTH-1];

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      last_bit  = (cnt == CW'(WIDTH - 1));
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every digit in parallel before the shift
   always_comb begin
      bcd_adj = bcd_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_scratch[4*d +: 4] >= 4'd5)
            bcd_adj[4*d +: 4] = bcd_scratch[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_reg     <= '0;
         bcd_scratch <= '0;
         ovf_scratch <= 1'b0;
         sign_reg    <= 1'b0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         bcd_out     <= '0;
         negative    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bin_reg     <= in_neg ? -bin_in : bin_in;
                  sign_reg    <= in_neg;
                  bcd_scratch <= '0;
                  ovf_scratch <= 1'b0;
                  cnt         <= '0;
               end
            end
            SHIFT: begin
               // A bit leaving the top digit means the value no longer fits in DIGITS
               bcd_scratch <= {bcd_adj[BW-2:0], bin_reg[WIDTH-1]};
               bin_reg     <= {bin_reg[WIDTH-2:0], 1'b0};
               ovf_scratch <= ovf_scratch | bcd_adj[BW-1];
               cnt         <= cnt + CW'(1);
            end
            DONE: begin
               bcd_out   <= bcd_scratch;
               negative  <= sign_reg;
               overflow  <= ovf_scratch;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Scoreboard bench: three converter configurations (decimal-10, 4-digit, signed) share one stimulus
// stream; expected results come from a plain-arithmetic decimal model, checked by a separate monitor.
module tb_conversor_bin_bcd_seq;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] bin_in;
   logic        r0, r1, r2;
   logic        v0, v1, v2;
   logic        n0, n1, n2;
   logic        o0, o1, o2;
   logic [39:0] b0, b2;
   logic [15:0] b1;
   logic [101:0] outs;

   always #5 clk = ~clk;

   conversor_bin_bcd_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0)) u_dec (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .bin_in(bin_in),
      .out_valid(v0), .bcd_out(b0), .negative(n0), .overflow(o0));

   conversor_bin_bcd_seq #(.WIDTH(32), .DIGITS(4), .SIGNED(1'b0)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .bin_in(bin_in),
      .out_valid(v1), .bcd_out(b1), .negative(n1), .overflow(o1));

   conversor_bin_bcd_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .bin_in(bin_in),
      .out_valid(v2), .bcd_out(b2), .negative(n2), .overflow(o2));

   assign outs = {b0, b1, b2, n0, n1, n2, o0, o1, o2};

   typedef struct packed {
      int          due;
      logic [39:0] e0;
      logic [15:0] e1;
      logic [39:0] e2;
      logic        en2;
      logic [2:0]  eo;
   } exp_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   int     next_ready = 0;
   int     n_acc   = 0;
   bit     acc_with_ov = 1'b0;
   exp_t   sbq[$];
   logic [101:0] prev_outs;
   logic   pov;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [39:0] ref_bcd(input longint unsigned mag, input int digits,
                                           output logic ovf);
      longint unsigned lim, v;
      logic [39:0] r;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      ovf = (mag >= lim);
      v = mag % lim;
      r = '0;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic exp_t model(input logic [31:0] x, input int due);
      exp_t        e;
      logic        ov;
      logic [39:0] t;
      int          sx;
      longint      lx;
      e     = '0;
      e.due = due;
      e.e0  = ref_bcd({32'd0, x}, 10, ov);
      e.eo[0] = ov;
      t     = ref_bcd({32'd0, x}, 4, ov);
      e.e1  = t[15:0];
      e.eo[1] = ov;
      sx    = x;
      lx    = sx;
      e.en2 = (lx < 0);
      e.e2  = ref_bcd((lx < 0) ? -lx : lx, 10, ov);
      e.eo[2] = ov;
      return e;
   endfunction

   // Monitor: samples just before each rising edge
   initial begin
      exp_t e;
      prev_outs = '0;
      pov = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         cyc++;
         if (!rst_n) begin
            sbq.delete();
            next_ready = 0;
            pov = 1'b0;
            chk("reset_outputs", outs, '0);
            chk("reset_ready_valid", {r0, r1, r2, v0, v1, v2}, 6'b111000);
            prev_outs = outs;
         end else begin
            chk("in_ready", {r0, r1, r2}, {3{cyc >= next_ready}});
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
               fail("missing_out_valid");
               e = sbq.pop_front();
            end
            if (v0 | v1 | v2) begin
               chk("out_valid_all", {v0, v1, v2}, 3'b111);
               chk("out_valid_single_cycle", pov, 1'b0);
               if (sbq.size() == 0) fail("spurious_out_valid");
               else begin
                  e = sbq.pop_front();
                  chk("latency", cyc, e.due);
                  chk("bcd_dec", b0, e.e0);
                  chk("bcd_4dig", b1, e.e1);
                  chk("bcd_signed", b2, e.e2);
                  chk("negative", {n0, n1, n2}, {2'b00, e.en2});
                  chk("overflow", {o0, o1, o2}, {e.eo[0], e.eo[1], e.eo[2]});
               end
            end else begin
               chk("outputs_stable", outs, prev_outs);
            end
            if (in_valid && r0) begin
               sbq.push_back(model(bin_in, cyc + W + 2));
               next_ready  = cyc + W + 2;
               n_acc++;
               acc_with_ov = v0;
            end
            pov = v0 | v1 | v2;
            prev_outs = outs;
         end
      end
   end

   task automatic wait_acc(input int target, input string nm);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (n_acc >= target) got = 1'b1;
      end
      if (!got) fail(nm);
   endtask

   task automatic send(input logic [31:0] v);
      int old;
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = v;
      old      = n_acc;
      wait_acc(old + 1, "accept_timeout");
      in_valid = 1'b0;
      bin_in   = $urandom;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (sbq.size() == 0 && r0) done = 1'b1;
      end
      if (!done) fail("drain_timeout");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dir [8];
      logic [31:0] v;
      int old;
      dir = '{32'hFFFF_FFFF, 32'd12345, 32'd9999, 32'h8000_0000,
              32'd999999999, 32'd1000000000, 32'd10000, 32'd1};
      rst_n    = 1'b0;
      in_valid = 1'b0;
      bin_in   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      send(32'd0);
      wait_idle();

      // Back-to-back sends: the next value is held while the converter is busy
      foreach (dir[i]) send(dir[i]);
      wait_idle();

      // Reset mid-conversion aborts the result
      send(32'd1234);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send(32'd56);
      wait_idle();

      // in_valid held high, data changes mid-conversion
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = 32'd7;
      old      = n_acc;
      wait_acc(old + 1, "held_accept1_timeout");
      repeat (10) @(negedge clk);
      bin_in = 32'd8;
      wait_acc(old + 2, "held_accept2_timeout");
      chk("accept_on_out_valid", acc_with_ov, 1'b1);
      in_valid = 1'b0;
      wait_idle();

      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 99999);
            2:       v = 32'd9990 + $urandom_range(0, 20);
            default: v = 32'h7FFF_FFF0 + $urandom_range(0, 31);
         endcase
         send(v);
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
